// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode field constants and the fetch FSM state type.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package mips_pkg;

    // Primary opcode field values, Inst[31:26]
    localparam logic [5:0] OP_R   = 6'd0;
    localparam logic [5:0] OP_J   = 6'd2;
    localparam logic [5:0] OP_JAL = 6'd3;
    localparam logic [5:0] OP_BEQ = 6'd4;
    localparam logic [5:0] OP_BNE = 6'd5;
    localparam logic [5:0] OP_LW  = 6'd35;
    localparam logic [5:0] OP_SW  = 6'd43;

    typedef enum logic [1:0] {
        RESET_WAIT = 2'd0,
        REQ        = 2'd1,
        EXEC       = 2'd2,
        HALT       = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/next_pc.sv
// Next-PC selector: jump > taken branch (beq/bne) > sequential PC+4.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is used.
//
// Ports:
//   pc_plus4          current PC + 4
//   jump_index        Inst[25:0] jump target field
//   imm_ext           sign-extended immediate (word offset for branches)
//   jump, branch, branch_not_equal, zero   decoder/ALU controls
//   npc               selected next PC
module next_pc (
    input  logic [31:0] pc_plus4,
    input  logic [25:0] jump_index,
    input  logic [31:0] imm_ext,
    input  logic        jump,
    input  logic        branch,
    input  logic        branch_not_equal,
    input  logic        zero,
    output logic [31:0] npc
);
    import mips_pkg::*;

    logic        taken;
    logic [31:0] branch_target;

    assign taken         = (branch & zero) | (branch_not_equal & ~zero);
    // Offset is in words; the shift drops imm_ext[31:30], wrapping mod 2^32.
    assign branch_target = pc_plus4 + (imm_ext << 2);

    always_comb begin
        npc = pc_plus4;
        if (jump) begin
            // Jump stays within the current 256 MB region of PC+4.
            npc = {pc_plus4[31:28], jump_index, 2'b00};
        end else if (taken) begin
            npc = branch_target;
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: PC register, memory request handshake, instruction register, next-PC update.
// Latency: Inst_Valid rises one cycle after the Imem_Ready cycle; minimum instruction period is 2 cycles.
// Backpressure: holds Imem_Req until Imem_Ready; MAX_WAIT stalled cycles or a misaligned next PC halts with Fetch_Err.
//
// Ports:
//   Clk, Reset_N            clock, asynchronous active-low reset
//   Imem_Req, Imem_Addr     memory read request and byte address (Imem_Addr == PC)
//   Imem_Ready, Imem_Data   memory response strobe and instruction word
//   Branch, Branch_Not_Equal, Jump, Zero, Imm_Ext   control/ALU inputs for the executing instruction
//   Inst, Inst_31_26        instruction register and its opcode field
//   PC_Plus4                PC + 4 (jal link value)
//   Inst_Valid              one-cycle execute strobe
//   Fetch_Err               sticky error, cleared only by reset
module inst_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          MAX_WAIT = 15
) (
    input  logic        Clk,
    input  logic        Reset_N,
    output logic        Imem_Req,
    output logic [31:0] Imem_Addr,
    input  logic        Imem_Ready,
    input  logic [31:0] Imem_Data,
    input  logic        Branch,
    input  logic        Branch_Not_Equal,
    input  logic        Jump,
    input  logic        Zero,
    input  logic [31:0] Imm_Ext,
    output logic [31:0] Inst,
    output logic [5:0]  Inst_31_26,
    output logic [31:0] PC_Plus4,
    output logic        Inst_Valid,
    output logic        Fetch_Err
);

    localparam int WCW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    // Count value seen on the stalled cycle that reaches MAX_WAIT.
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(MAX_WAIT - 1);

    fetch_state_t   state;
    logic [31:0]    pc;
    logic [31:0]    npc;
    logic [WCW-1:0] wait_cnt;

    assign Imem_Addr  = pc;
    assign PC_Plus4   = pc + 32'd4;
    assign Inst_31_26 = Inst[31:26];

    next_pc u_next_pc (
        .pc_plus4         (PC_Plus4),
        .jump_index       (Inst[25:0]),
        .imm_ext          (Imm_Ext),
        .jump             (Jump),
        .branch           (Branch),
        .branch_not_equal (Branch_Not_Equal),
        .zero             (Zero),
        .npc              (npc)
    );

    // Imem_Req and Inst_Valid are registered and set on entry to REQ/EXEC,
    // so they are already correct during the first cycle of each state.
    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            state      <= RESET_WAIT;
            pc         <= RESET_PC;
            Inst       <= '0;
            Imem_Req   <= 1'b0;
            Inst_Valid <= 1'b0;
            Fetch_Err  <= 1'b0;
            wait_cnt   <= '0;
        end else begin
            case (state)
                RESET_WAIT: begin
                    state    <= REQ;
                    Imem_Req <= 1'b1;
                    wait_cnt <= '0;
                end
                REQ: begin
                    if (Imem_Ready) begin
                        Inst       <= Imem_Data;
                        Imem_Req   <= 1'b0;
                        Inst_Valid <= 1'b1;
                        state      <= EXEC;
                    end else if (wait_cnt == WAIT_LAST) begin
                        Fetch_Err <= 1'b1;
                        Imem_Req  <= 1'b0;
                        state     <= HALT;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                EXEC: begin
                    Inst_Valid <= 1'b0;
                    if (npc[1:0] != 2'b00) begin
                        // PC keeps its old value so the faulting instruction is visible.
                        Fetch_Err <= 1'b1;
                        state     <= HALT;
                    end else begin
                        pc       <= npc;
                        Imem_Req <= 1'b1;
                        wait_cnt <= '0;
                        state    <= REQ;
                    end
                end
                HALT: begin
                    Imem_Req   <= 1'b0;
                    Inst_Valid <= 1'b0;
                end
                default: begin
                    state <= HALT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed PC sequences plus randomized fetches
// checked against a transaction-level next-PC model and a memory responder with random latency.
module tb_inst_fetch;
    import mips_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int          MAXW   = 15;

    logic        Clk = 1'b0;
    logic        Reset_N = 1'b0;
    logic        Imem_Req;
    logic [31:0] Imem_Addr;
    logic        Imem_Ready = 1'b0;
    logic [31:0] Imem_Data = '0;
    logic        Branch = 1'b0;
    logic        Branch_Not_Equal = 1'b0;
    logic        Jump = 1'b0;
    logic        Zero = 1'b0;
    logic [31:0] Imm_Ext = '0;
    logic [31:0] Inst;
    logic [5:0]  Inst_31_26;
    logic [31:0] PC_Plus4;
    logic        Inst_Valid;
    logic        Fetch_Err;

    inst_fetch #(.RESET_PC(RST_PC), .MAX_WAIT(MAXW)) dut (
        .Clk              (Clk),
        .Reset_N          (Reset_N),
        .Imem_Req         (Imem_Req),
        .Imem_Addr        (Imem_Addr),
        .Imem_Ready       (Imem_Ready),
        .Imem_Data        (Imem_Data),
        .Branch           (Branch),
        .Branch_Not_Equal (Branch_Not_Equal),
        .Jump             (Jump),
        .Zero             (Zero),
        .Imm_Ext          (Imm_Ext),
        .Inst             (Inst),
        .Inst_31_26       (Inst_31_26),
        .PC_Plus4         (PC_Plus4),
        .Inst_Valid       (Inst_Valid),
        .Fetch_Err        (Fetch_Err)
    );

    always #5 Clk = ~Clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_pc  = RST_PC;

    logic [5:0] ops [7];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Architectural next-PC rule, stated directly in terms of addresses.
    function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [31:0] inst,
                                             input logic j, input logic b, input logic bne,
                                             input logic z, input logic [31:0] imm);
        logic [31:0] seq;
        seq = pc + 32'd4;
        if (j)
            return {seq[31:28], inst[25:0], 2'b00};
        if ((b && z) || (bne && !z))
            return seq + imm * 32'd4;
        return seq;
    endfunction

    // Outside EXEC the control inputs must have no effect, so drive noise.
    task automatic scramble_ctrl();
        Jump             = 1'($urandom);
        Branch           = 1'($urandom);
        Branch_Not_Equal = 1'($urandom);
        Zero             = 1'($urandom);
        Imm_Ext          = $urandom;
    endtask

    // Called at a negedge while the DUT is requesting; returns at the negedge of the next request.
    task automatic do_fetch(input int delay, input logic [31:0] data, input logic j, input logic b,
                            input logic bne, input logic z, input logic [31:0] imm);
        for (int i = 0; i <= delay; i++) begin
            check_val("req_high", 32'(Imem_Req), 32'd1);
            check_val("req_addr", Imem_Addr, exp_pc);
            check_val("valid_low_in_req", 32'(Inst_Valid), 32'd0);
            scramble_ctrl();
            Imem_Ready = (i == delay);
            Imem_Data  = (i == delay) ? data : $urandom;
            @(negedge Clk);
        end
        check_val("exec_valid", 32'(Inst_Valid), 32'd1);
        check_val("exec_req_low", 32'(Imem_Req), 32'd0);
        check_val("exec_inst", Inst, data);
        check_val("exec_opcode", 32'(Inst_31_26), 32'(data[31:26]));
        check_val("exec_pc_plus4", PC_Plus4, exp_pc + 32'd4);
        check_val("exec_no_err", 32'(Fetch_Err), 32'd0);
        Jump             = j;
        Branch           = b;
        Branch_Not_Equal = bne;
        Zero             = z;
        Imm_Ext          = imm;
        Imem_Ready       = 1'($urandom);   // must be ignored in EXEC
        Imem_Data        = $urandom;
        exp_pc = ref_next(exp_pc, data, j, b, bne, z, imm);
        @(negedge Clk);
        Imem_Ready = 1'b0;
    endtask

    task automatic plain_fetch(input int delay);
        do_fetch(delay, {OP_R, 26'($urandom)}, 1'b0, 1'b0, 1'b0, 1'($urandom), $urandom);
    endtask

    // Assert reset at a negedge, check async values, release, and land on the first request.
    task automatic reset_dut();
        Reset_N = 1'b0;
        #1;
        check_val("rst_req", 32'(Imem_Req), 32'd0);
        check_val("rst_valid", 32'(Inst_Valid), 32'd0);
        check_val("rst_err", 32'(Fetch_Err), 32'd0);
        check_val("rst_inst", Inst, 32'd0);
        check_val("rst_addr", Imem_Addr, RST_PC);
        @(negedge Clk);
        @(negedge Clk);
        check_val("rst_inst_hold", Inst, 32'd0);
        Reset_N    = 1'b1;
        Imem_Ready = 1'b0;
        exp_pc     = RST_PC;
        @(negedge Clk);
        check_val("post_rst_req", 32'(Imem_Req), 32'd1);
        check_val("post_rst_addr", Imem_Addr, RST_PC);
        for (int k = 0; k < 20 && !Imem_Req; k++) @(negedge Clk);
        if (!Imem_Req) begin
            $display("FAIL req_after_reset: got no request, expected one within 20 cycles");
            $fatal(1, "no fetch request after reset");
        end
    endtask

    initial begin
        logic [31:0] d;
        logic        j, b, bne;
        ops = '{OP_R, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_LW, OP_SW};

        @(negedge Clk);
        reset_dut();

        // Sequential fetch with zero memory latency: 0x0, 0x4, 0x8, valid every 2nd cycle.
        plain_fetch(0);
        plain_fetch(0);
        // Jump from 0x8 to 0x100.
        do_fetch(0, {OP_J, 26'h40}, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        // beq taken at 0x100, offset -2 words -> 0xFC.
        do_fetch(0, {OP_BEQ, 26'h0}, 1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE);
        check_val("beq_taken_target", exp_pc, 32'h0000_00FC);
        do_fetch(1, {OP_J, 26'h40}, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        // beq not taken at 0x100 -> 0x104.
        do_fetch(2, {OP_BEQ, 26'h0}, 1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFE);
        check_val("beq_not_taken_addr", Imem_Addr, 32'h0000_0104);
        // Large forward branch into 0x3000_0000, then jump within that region.
        do_fetch(0, {OP_BEQ, 26'h0}, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0BFF_FFBE);
        check_val("far_branch_addr", Imem_Addr, 32'h3000_0000);
        do_fetch(0, 32'h0800_0010, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        check_val("region_jump_addr", Imem_Addr, 32'h3000_0040);
        // Branch to the top word, then wrap to zero.
        do_fetch(3, {OP_BNE, 26'h0}, 1'b0, 1'b0, 1'b1, 1'b0, 32'h33FF_FFEE);
        check_val("top_word_addr", Imem_Addr, 32'hFFFF_FFFC);
        plain_fetch(0);
        check_val("wrap_addr", Imem_Addr, 32'h0000_0000);
        check_val("wrap_no_err", 32'(Fetch_Err), 32'd0);
        // Longest tolerated stall: ready on the last allowed cycle.
        plain_fetch(MAXW - 1);

        // Randomized fetches with random latency, opcodes and (sometimes conflicting) controls.
        for (int n = 0; n < 60; n++) begin
            d   = {ops[$urandom_range(0, 6)], 26'($urandom)};
            j   = (d[31:26] == OP_J) || (d[31:26] == OP_JAL);
            b   = (d[31:26] == OP_BEQ);
            bne = (d[31:26] == OP_BNE);
            if ($urandom_range(0, 3) == 0) {j, b, bne} = 3'($urandom);
            do_fetch($urandom_range(0, 4), d, j, b, bne, 1'($urandom), $urandom);
        end

        // bne taken at 0x10 with offset 1 word -> 0x18, then reset during the request.
        reset_dut();
        for (int n = 0; n < 4; n++) plain_fetch(0);
        check_val("bne_pc", Imem_Addr, 32'h0000_0010);
        do_fetch(0, {OP_BNE, 26'h0}, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0001);
        check_val("bne_target", Imem_Addr, 32'h0000_0018);
        Imem_Ready = 1'b1;
        Imem_Data  = 32'hDEAD_BEEF;
        reset_dut();

        // Memory never ready: error after MAX_WAIT stalled cycles, then halted until reset.
        for (int k = 0; k < MAXW; k++) begin
            check_val("stall_req", 32'(Imem_Req), 32'd1);
            check_val("stall_no_err", 32'(Fetch_Err), 32'd0);
            scramble_ctrl();
            Imem_Ready = 1'b0;
            @(negedge Clk);
        end
        check_val("timeout_err", 32'(Fetch_Err), 32'd1);
        check_val("timeout_req_low", 32'(Imem_Req), 32'd0);
        for (int k = 0; k < 5; k++) begin
            scramble_ctrl();
            Imem_Ready = 1'($urandom);
            Imem_Data  = $urandom;
            @(negedge Clk);
            check_val("halt_req", 32'(Imem_Req), 32'd0);
            check_val("halt_valid", 32'(Inst_Valid), 32'd0);
            check_val("halt_err_sticky", 32'(Fetch_Err), 32'd1);
        end
        Imem_Ready = 1'b0;
        reset_dut();
        plain_fetch(1);
        plain_fetch(0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 The block SHALL use one clock, Clk, and an asynchronous active-low reset, Reset_N.
REQ-002 Parameter RESET_PC, 32'h0000_0000: PC value loaded at reset.
REQ-003 Parameter MAX_WAIT, 15: maximum cycles allowed with Imem_Req high and Imem_Ready low.
REQ-004 Clk  input  1  rising-edge clock.
REQ-005 Reset_N  input  1  asynchronous active-low reset.
REQ-006 Imem_Req  output  1  instruction memory read request.
REQ-007 Imem_Addr  output  32  instruction memory byte address; always equals PC.
REQ-008 Imem_Ready  input  1  memory returns valid data on Imem_Data this cycle.
REQ-009 Imem_Data  input  32  instruction word.
REQ-010 Branch, Branch_Not_Equal, Jump  input  1 each  control-decoder outputs for the current instruction.
REQ-011 Zero  input  1  ALU equality flag for the current instruction.
REQ-012 Imm_Ext  input  32  sign-extended immediate of the current instruction.
REQ-013 Inst  output  32  instruction register.
REQ-014 Inst_31_26  output  6  opcode field Inst[31:26], driving the control decoder.
REQ-015 PC_Plus4  output  32  PC+4, used as the jal link value.
REQ-016 Inst_Valid  output  1  one-cycle strobe: Inst is valid and executes this cycle.
REQ-017 Fetch_Err  output  1  sticky error flag.

Function
REQ-018 FSM states SHALL be RESET_WAIT, REQ, EXEC and HALT.
REQ-019 RESET_WAIT SHALL last exactly one cycle after reset release, then go to REQ.
REQ-020 In REQ, Imem_Req SHALL be 1; on Imem_Ready=1, Inst SHALL load Imem_Data and the FSM SHALL go to EXEC.
REQ-021 In EXEC, Inst_Valid SHALL be 1 for exactly one cycle, PC SHALL load next-PC, and the FSM SHALL return to REQ.
REQ-022 Fetch latency: Inst_Valid SHALL rise 1 cycle after the Imem_Ready cycle; the minimum instruction period is 2 cycles.
REQ-023 Next-PC priority, evaluated in EXEC:
  - Jump=1 -> {PC_Plus4[31:28], Inst[25:0], 2'b00}.
  - Else if (Branch & Zero) | (Branch_Not_Equal & ~Zero) -> PC_Plus4 + (Imm_Ext << 2).
  - Else -> PC_Plus4.
REQ-024 All PC arithmetic SHALL be 32-bit modulo 2^32; PC 32'hFFFF_FFFC increments to 32'h0000_0000 with no error.
REQ-025 A wait counter SHALL count REQ cycles with Imem_Ready=0 and clear on entry to REQ.
  - Reaching MAX_WAIT -> Fetch_Err=1, FSM to HALT.
REQ-026 A next-PC with bits [1:0] != 0 SHALL set Fetch_Err and send the FSM to HALT; PC SHALL keep its old value.
REQ-027 HALT SHALL hold Imem_Req=0 and Inst_Valid=0 until reset.
REQ-028 Imem_Ready SHALL be ignored outside REQ.
REQ-029 Branch, Branch_Not_Equal and Jump SHALL be ignored outside EXEC.

Reset
REQ-030 On Reset_N=0, asynchronously:
  - PC=RESET_PC; Inst=0 (opcode 0, an R-type no-op).
  - Imem_Req=0, Inst_Valid=0, Fetch_Err=0, wait counter=0.
  - FSM to RESET_WAIT.
REQ-031 Reset asserted mid-fetch SHALL abandon the request in the same cycle; no partial Inst load.

Structure
REQ-032 Shared package mips_pkg SHALL hold the opcode constants (R=0, J=2, JAL=3, BEQ=4, BNE=5, LW=35, SW=43) and the FSM state enum.
REQ-033 Next-PC selection SHALL be a combinational sub-module, next_pc, instantiated once.

Verification
REQ-034 Reset, Imem_Ready tied 1 -> Imem_Addr sequence 0x0, 0x4, 0x8; Inst_Valid every 2nd cycle.
REQ-035 PC=0x100, beq, Zero=1, Imm_Ext=0xFFFFFFFE -> next Imem_Addr 0x0FC; repeat with Zero=0 -> 0x104.
REQ-036 PC=0x3000_0000, Inst=0x0800_0010, Jump=1 -> next Imem_Addr 0x3000_0040; PC_Plus4=0x3000_0004 during EXEC.
REQ-037 Imem_Ready held 0 for 15 cycles -> Fetch_Err=1 and Imem_Req=0 thereafter; Reset_N pulse -> Fetch_Err=0, Imem_Addr=RESET_PC.
REQ-038 Imm_Ext=1 with a taken bne at PC=0x10 -> target 0x18; then Reset_N asserted during REQ -> Imem_Req=0 in the same cycle.
